// File: rtl/seg_dynamic_drv.sv
// Six-digit multiplexed 7-segment driver: sequential binary-to-BCD, blanking, sign, points.
// Optional SEG_ACTIVE_HIGH_EN inverts the segment bus for common-cathode displays.
module seg_dynamic_drv #(
  parameter logic [15:0] SCAN_CNT_MAX = 16'd49_999,
  parameter logic [19:0] DATA_MAX     = 20'd999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  input  logic        sign,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

`ifdef SEG_ACTIVE_HIGH_EN
  localparam logic [7:0] SEG_OFF = 8'h00;
`else
  localparam logic [7:0] SEG_OFF = 8'hFF;
`endif

  typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_t;

  conv_state_t state, next_state;

  logic [19:0] data_sat;
  logic [19:0] data_last;
  logic [19:0] shift_reg;
  logic [23:0] bcd_acc;
  logic [23:0] bcd_adj;
  logic [4:0]  bit_cnt;
  logic        first_flag;
  logic [23:0] disp_reg;
  logic        data_changed;
  logic        conv_start;
  logic        conv_step;
  logic        conv_load;

  logic [15:0] scan_cnt;
  logic [2:0]  idx;
  logic [2:0]  msd;
  logic [3:0]  nib;
  logic [7:0]  code;
  logic [7:0]  seg_pol;

  assign data_sat     = (data > DATA_MAX) ? DATA_MAX : data;
  assign data_changed = first_flag || (data_sat != data_last);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (data_changed) next_state = CONV;
      CONV:    if (bit_cnt == 5'd19) next_state = LOAD;
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    conv_start = 1'b0;
    conv_step  = 1'b0;
    conv_load  = 1'b0;
    case (state)
      IDLE:    conv_start = data_changed;
      CONV:    conv_step  = 1'b1;
      LOAD:    conv_load  = 1'b1;
      default: ;
    endcase
  end

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int n = 0; n < 6; n++) begin
      if (bcd_acc[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_acc[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      first_flag <= 1'b1;
      data_last  <= '0;
      shift_reg  <= '0;
      bcd_acc    <= '0;
      bit_cnt    <= '0;
      disp_reg   <= '0;
    end else begin
      if (conv_start) begin
        first_flag <= 1'b0;
        data_last  <= data_sat;
        shift_reg  <= data_sat;
        bcd_acc    <= '0;
        bit_cnt    <= '0;
      end
      if (conv_step) begin
        bcd_acc   <= {bcd_adj[22:0], shift_reg[19]};
        shift_reg <= {shift_reg[18:0], 1'b0};
        bit_cnt   <= bit_cnt + 5'd1;
      end
      if (conv_load) disp_reg <= bcd_acc;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_CNT_MAX) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // A decimal point keeps its digit (and all lower ones) visible.
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (disp_reg[4*i +: 4] != 4'd0 || point[i]) msd = 3'(i);
    end
  end

  assign nib = disp_reg[{idx, 2'b00} +: 4];

  always_comb begin
    code = 8'hFF;
    if (idx == 3'd0 || idx <= msd) begin
      case (nib)
        4'd0:    code = 8'hC0;
        4'd1:    code = 8'hF9;
        4'd2:    code = 8'hA4;
        4'd3:    code = 8'hB0;
        4'd4:    code = 8'h99;
        4'd5:    code = 8'h92;
        4'd6:    code = 8'h82;
        4'd7:    code = 8'hF8;
        4'd8:    code = 8'h80;
        4'd9:    code = 8'h90;
        default: code = 8'hFF;
      endcase
    end else if (sign && msd < 3'd5 && idx == msd + 3'd1) begin
      code = 8'hBF;
    end
    if (point[idx]) code[7] = 1'b0;
  end

`ifdef SEG_ACTIVE_HIGH_EN
  assign seg_pol = ~code;
`else
  assign seg_pol = code;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sel <= '0;
      seg <= SEG_OFF;
    end else if (seg_en) begin
      sel <= 6'd1 << idx;
      seg <= seg_pol;
    end else begin
      sel <= '0;
      seg <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_drv.sv
// Directed bench for seg_dynamic_drv with a 4-cycle digit scan period.
module tb_seg_dynamic_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        seg_en;
  logic        sign;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  seg_dynamic_drv #(.SCAN_CNT_MAX(16'd3), .DATA_MAX(20'd999_999)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .data     (data),
    .point    (point),
    .seg_en   (seg_en),
    .sign     (sign),
    .sel      (sel),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pol(input logic [7:0] x);
`ifdef SEG_ACTIVE_HIGH_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input logic [5:0] want);
    for (int k = 0; k < 40 && sel !== want; k++) step();
  endtask

  task automatic check_digit(input string tag, input int i, input logic [7:0] exp);
    logic [5:0] want;
    want = 6'd1 << i;
    wait_sel(want);
    check({tag, "_sel"}, {18'd0, sel}, {18'd0, want});
    check(tag, {16'd0, seg}, {16'd0, pol(exp)});
  endtask

  task automatic check_all(input string tag, input logic [47:0] exp);
    for (int i = 0; i < 6; i++) check_digit($sformatf("%s_d%0d", tag, i), i, exp[8*i +: 8]);
  endtask

  initial begin
    rst_n = 1'b0; data = 20'd0; point = 6'd0; seg_en = 1'b1; sign = 1'b0;

    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_sel", {18'd0, sel}, 24'd0);
      check("rst_seg", {16'd0, seg}, {16'd0, pol(8'hFF)});
    end
    rst_n = 1'b1;
    repeat (30) step();
    check_all("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    // Conversion latency: display register updates exactly 22 edges after the change.
    data = 20'd123456;
    repeat (21) step();
    check("lat_pre", dut.disp_reg, 24'h000000);
    step();
    check("lat_post", dut.disp_reg, 24'h123456);
    check_all("n123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    data = 20'd42; sign = 1'b1;
    repeat (30) step();
    check_all("neg42", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});
    data = 20'd654321;
    repeat (30) step();
    check_all("neg_full", {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9});

    data = 20'd5; sign = 1'b0; point = 6'b000100;
    repeat (30) step();
    check_all("pt5", {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92});
    point = 6'd0;

    data = 20'hFFFFF;
    repeat (30) step();
    check_all("sat", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

    data = 20'd0;
    repeat (30) step();
    check("clr", dut.disp_reg, 24'h000000);

    // Change arriving mid-conversion is picked up only after the running LOAD.
    data = 20'hFFFFF;
    repeat (5) step();
    data = 20'd7;
    repeat (17) step();
    check("mid_first", dut.disp_reg, 24'h999999);
    repeat (21) step();
    check("mid_hold", dut.disp_reg, 24'h999999);
    step();
    check("mid_second", dut.disp_reg, 24'h000007);
    check_all("seven", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8});

    // Sync to the first cycle of digit 4, blank for 10 edges, then resume.
    wait_sel(6'b001000);
    wait_sel(6'b010000);
    check("sync_sel", {18'd0, sel}, 24'h000010);
    seg_en = 1'b0;
    step();
    check("off_sel", {18'd0, sel}, 24'd0);
    check("off_seg", {16'd0, seg}, {16'd0, pol(8'hFF)});
    repeat (9) step();
    check("off_hold_sel", {18'd0, sel}, 24'd0);
    seg_en = 1'b1;
    step();
    check("resume_sel", {18'd0, sel}, 24'h000001);
    check("resume_seg", {16'd0, seg}, {16'd0, pol(8'hF8)});
    step();
    check("resume_next_sel", {18'd0, sel}, 24'h000002);
    check("resume_next_seg", {16'd0, seg}, {16'd0, pol(8'hFF)});
    check("no_reconv", dut.disp_reg, 24'h000007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
